// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - in-order instruction fetch with credit-limited issue, return buffer and redirect flush
// 32-bit buses are [31:0] here; the MSB-first [0:31] numbering maps bit 0 onto bit 31.
module fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'h8002_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        stall,
   input  logic        redirect,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic [31:0] insn,
   output logic [31:0] pc,
   output logic        valid_insn
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [31:0]   fetch_pc;
   logic [CW-1:0] inflight;
   logic [CW-1:0] buf_count;
   logic [CW-1:0] drop;
   logic [AW-1:0] tag_wr, tag_rd, buf_wr, buf_rd;
   logic [31:0]   tag_mem  [DEPTH];
   logic [31:0]   buf_insn [DEPTH];
   logic [31:0]   buf_pc   [DEPTH];

   logic [CW:0]   credit_used;
   logic [31:0]   resp_tag;
   logic          issue, out_load, buf_empty, resp_keep, bypass, buf_push, buf_pop;

   // Every issued request holds a slot until its word leaves the buffer, so the buffer cannot overflow.
   assign credit_used = {1'b0, inflight} + {1'b0, buf_count};
   assign issue       = !rst && !redirect && (credit_used < (CW+1)'(DEPTH));
   assign imem_req    = issue;
   assign imem_addr   = fetch_pc;
   assign resp_tag    = tag_mem[tag_rd];
   assign buf_empty   = (buf_count == '0);
   assign out_load    = !stall || !valid_insn;
   assign resp_keep   = imem_rvalid && !redirect && (drop == '0);
   assign bypass      = resp_keep && out_load && buf_empty;
   assign buf_push    = resp_keep && !bypass;
   assign buf_pop     = out_load && !buf_empty && !redirect;

   always_ff @(posedge clk) begin
      if (issue)
         tag_mem[tag_wr] <= fetch_pc;
      if (buf_push) begin
         buf_insn[buf_wr] <= imem_rdata;
         buf_pc[buf_wr]   <= resp_tag;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fetch_pc   <= RESET_PC;
         inflight   <= '0;
         drop       <= '0;
         tag_wr     <= '0;
         tag_rd     <= '0;
         buf_wr     <= '0;
         buf_rd     <= '0;
         buf_count  <= '0;
         valid_insn <= 1'b0;
         insn       <= '0;
         pc         <= '0;
      end else begin
         if (issue)
            tag_wr <= tag_wr + AW'(1);
         if (imem_rvalid)
            tag_rd <= tag_rd + AW'(1);

         case ({issue, imem_rvalid})
            2'b10:   inflight <= inflight + CW'(1);
            2'b01:   inflight <= inflight - CW'(1);
            default: ;
         endcase

         if (redirect) begin
            fetch_pc  <= redirect_pc;
            // Everything still outstanding after this cycle's response belongs to the old stream.
            drop      <= inflight - CW'(imem_rvalid);
            buf_wr    <= '0;
            buf_rd    <= '0;
            buf_count <= '0;
            valid_insn <= 1'b0;
         end else begin
            if (issue)
               fetch_pc <= fetch_pc + 32'd4;
            if (imem_rvalid && drop != '0)
               drop <= drop - CW'(1);
            if (buf_push)
               buf_wr <= buf_wr + AW'(1);
            if (buf_pop)
               buf_rd <= buf_rd + AW'(1);
            case ({buf_push, buf_pop})
               2'b10:   buf_count <= buf_count + CW'(1);
               2'b01:   buf_count <= buf_count - CW'(1);
               default: ;
            endcase

            if (out_load) begin
               if (!buf_empty) begin
                  insn       <= buf_insn[buf_rd];
                  pc         <= buf_pc[buf_rd];
                  valid_insn <= 1'b1;
               end else if (bypass) begin
                  insn       <= imem_rdata;
                  pc         <= resp_tag;
                  valid_insn <= 1'b1;
               end else begin
                  valid_insn <= 1'b0;
               end
            end
         end
      end
   end
endmodule
